// File: rtl/sprite_overlay.sv
// Hardware pointer sprite compositor: overlays a 2bpp SPRITE_W x SPRITE_H bitmap on scanout video
// with a fixed 2-cycle latency on every output. Define SPRITE_SCALE2X_EN to add 2x pixel scaling.
module sprite_overlay #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int COORD_W  = 12
) (
  input  logic                                 dvi_clk,
  input  logic                                 areset,
  input  logic                                 sync_polarity,
  input  logic                                 in_hsync,
  input  logic                                 in_vsync,
  input  logic                                 in_active_video,
  input  logic [31:0]                          in_rgb,
  input  logic                                 sprite_enable,
  input  logic [COORD_W-1:0]                   sprite_x,
  input  logic [COORD_W-1:0]                   sprite_y,
`ifdef SPRITE_SCALE2X_EN
  input  logic                                 sprite_scale,
`endif
  input  logic                                 sprite_wr_en,
  input  logic [$clog2(SPRITE_W*SPRITE_H)-1:0] sprite_wr_addr,
  input  logic [1:0]                           sprite_wr_data,
  input  logic                                 sprite_col_wr_en,
  input  logic [1:0]                           sprite_col_idx,
  input  logic [23:0]                          sprite_col_data,
  output logic                                 out_hsync,
  output logic                                 out_vsync,
  output logic                                 out_active_video,
  output logic [31:0]                          out_rgb
);

  localparam int XB    = $clog2(SPRITE_W);
  localparam int YB    = $clog2(SPRITE_H);
  localparam int AW    = XB + YB;
  localparam int DEPTH = SPRITE_W * SPRITE_H;
  localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] WIN_W1    = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] WIN_H1    = COORD_W'(SPRITE_H);
`ifdef SPRITE_SCALE2X_EN
  localparam logic [COORD_W-1:0] WIN_W2    = COORD_W'(2 * SPRITE_W);
  localparam logic [COORD_W-1:0] WIN_H2    = COORD_W'(2 * SPRITE_H);
`endif

  logic               vs_now_s;
  logic               vs_edge_s;
  logic               vs_asserted_r;
  logic               sh_en_r;
  logic [COORD_W-1:0] sh_x_r;
  logic [COORD_W-1:0] sh_y_r;
`ifdef SPRITE_SCALE2X_EN
  logic               sh_scale_r;
`endif
  logic [COORD_W-1:0] hpos_r;
  logic [COORD_W-1:0] vpos_r;
  logic [COORD_W-1:0] dx_s;
  logic [COORD_W-1:0] dy_s;
  logic               in_win_s;
  logic               hit_s;
  logic [AW-1:0]      rd_addr_s;
  logic [1:0]         bitmap_mem [DEPTH];
  logic [1:0]         rd_idx_r;
  logic               hit_r;
  logic [31:0]        rgb_r;
  logic               hs_r;
  logic               vs_r;
  logic               de_r;
  logic [23:0]        col1_r;
  logic [23:0]        col2_r;
  logic [23:0]        col3_r;
  logic [23:0]        sprite_rgb_s;

  assign vs_now_s  = in_vsync ^ sync_polarity;
  assign vs_edge_s = vs_now_s & ~vs_asserted_r;

  // Vsync edge detector; sprite controls are sampled only here so a frame never tears
  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      vs_asserted_r <= 1'b0;
      sh_en_r       <= 1'b0;
      sh_x_r        <= {COORD_W{1'b0}};
      sh_y_r        <= {COORD_W{1'b0}};
`ifdef SPRITE_SCALE2X_EN
      sh_scale_r    <= 1'b0;
`endif
    end else begin
      vs_asserted_r <= vs_now_s;
      if (vs_edge_s) begin
        sh_en_r    <= sprite_enable;
        sh_x_r     <= sprite_x;
        sh_y_r     <= sprite_y;
`ifdef SPRITE_SCALE2X_EN
        sh_scale_r <= sprite_scale;
`endif
      end
    end
  end

  // Beam counters: hpos is the column of the pixel on the input, vpos counts active lines
  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      hpos_r <= {COORD_W{1'b0}};
      vpos_r <= {COORD_W{1'b0}};
    end else begin
      if (!in_active_video) begin
        hpos_r <= {COORD_W{1'b0}};
      end else if (hpos_r != COORD_MAX) begin
        hpos_r <= hpos_r + {{(COORD_W-1){1'b0}}, 1'b1};
      end
      // A vsync edge wins over a coincident end-of-line
      if (vs_edge_s) begin
        vpos_r <= {COORD_W{1'b0}};
      end else if (de_r && !in_active_video && vpos_r != COORD_MAX) begin
        vpos_r <= vpos_r + {{(COORD_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Window test and bitmap address for the pixel currently on the input
  always_comb begin
    dx_s = hpos_r - sh_x_r;
    dy_s = vpos_r - sh_y_r;
`ifdef SPRITE_SCALE2X_EN
    in_win_s  = sh_scale_r ? ((dx_s < WIN_W2) && (dy_s < WIN_H2))
                           : ((dx_s < WIN_W1) && (dy_s < WIN_H1));
    rd_addr_s = sh_scale_r ? {dy_s[YB:1], dx_s[XB:1]}
                           : {dy_s[YB-1:0], dx_s[XB-1:0]};
`else
    in_win_s  = (dx_s < WIN_W1) && (dy_s < WIN_H1);
    rd_addr_s = {dy_s[YB-1:0], dx_s[XB-1:0]};
`endif
    hit_s = sh_en_r && in_active_video && (hpos_r >= sh_x_r) && (vpos_r >= sh_y_r) && in_win_s;
  end

  // Bitmap RAM: registered read sees pre-write contents on an address collision
  always_ff @(posedge dvi_clk) begin
    if (sprite_wr_en) begin
      bitmap_mem[sprite_wr_addr] <= sprite_wr_data;
    end
    rd_idx_r <= bitmap_mem[rd_addr_s];
  end

  // Stage 1: hold pixel, syncs and hit flag alongside the RAM read
  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      hit_r <= 1'b0;
      rgb_r <= 32'h0000_0000;
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      de_r  <= 1'b0;
    end else begin
      hit_r <= hit_s;
      rgb_r <= in_rgb;
      hs_r  <= in_hsync;
      vs_r  <= in_vsync;
      de_r  <= in_active_video;
    end
  end

  // Colour registers 1..3; index 0 is the transparent slot and has no storage
  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      col1_r <= 24'h00_0000;
      col2_r <= 24'h00_0000;
      col3_r <= 24'h00_0000;
    end else if (sprite_col_wr_en) begin
      case (sprite_col_idx)
        2'd1:    col1_r <= sprite_col_data;
        2'd2:    col2_r <= sprite_col_data;
        2'd3:    col3_r <= sprite_col_data;
        default: ;
      endcase
    end
  end

  // Palette lookup of the bitmap index read in stage 1
  always_comb begin
    sprite_rgb_s = 24'h00_0000;
    case (rd_idx_r)
      2'd1:    sprite_rgb_s = col1_r;
      2'd2:    sprite_rgb_s = col2_r;
      2'd3:    sprite_rgb_s = col3_r;
      default: sprite_rgb_s = 24'h00_0000;
    endcase
  end

  // Stage 2: registered composited outputs
  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      out_hsync        <= 1'b0;
      out_vsync        <= 1'b0;
      out_active_video <= 1'b0;
      out_rgb          <= 32'h0000_0000;
    end else begin
      out_hsync        <= hs_r;
      out_vsync        <= vs_r;
      out_active_video <= de_r;
      out_rgb          <= (hit_r && (rd_idx_r != 2'd0)) ? {8'h00, sprite_rgb_s} : rgb_r;
    end
  end

endmodule

// File: tb/tb_sprite_overlay.sv
// Self-checking bench for sprite_overlay: frame-level reference model plus literal pixel probes.
// Builds with or without SPRITE_SCALE2X_EN.
module tb_sprite_overlay;

  localparam int W = 32;
  localparam int H = 32;

  logic        dvi_clk = 1'b0;
  logic        areset = 1'b0;
  logic        sync_polarity = 1'b1;
  logic        in_hsync = 1'b1;
  logic        in_vsync = 1'b1;
  logic        in_active_video = 1'b0;
  logic [31:0] in_rgb = 32'h0;
  logic        sprite_enable = 1'b0;
  logic [11:0] sprite_x = 12'd0;
  logic [11:0] sprite_y = 12'd0;
  logic        sprite_scale = 1'b0;
  logic        sprite_wr_en = 1'b0;
  logic [9:0]  sprite_wr_addr = 10'd0;
  logic [1:0]  sprite_wr_data = 2'd0;
  logic        sprite_col_wr_en = 1'b0;
  logic [1:0]  sprite_col_idx = 2'd0;
  logic [23:0] sprite_col_data = 24'h0;
  logic        out_hsync;
  logic        out_vsync;
  logic        out_active_video;
  logic [31:0] out_rgb;

  sprite_overlay dut (
    .dvi_clk(dvi_clk), .areset(areset), .sync_polarity(sync_polarity),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_active_video(in_active_video), .in_rgb(in_rgb),
    .sprite_enable(sprite_enable), .sprite_x(sprite_x), .sprite_y(sprite_y),
`ifdef SPRITE_SCALE2X_EN
    .sprite_scale(sprite_scale),
`endif
    .sprite_wr_en(sprite_wr_en), .sprite_wr_addr(sprite_wr_addr), .sprite_wr_data(sprite_wr_data),
    .sprite_col_wr_en(sprite_col_wr_en), .sprite_col_idx(sprite_col_idx),
    .sprite_col_data(sprite_col_data),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_active_video(out_active_video),
    .out_rgb(out_rgb)
  );

  always #5 dvi_clk = ~dvi_clk;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [31:0] rgb;
    int          x;
    int          y;
  } exp_t;

  exp_t        q[$];
  logic [31:0] got [int];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state
  logic [1:0]  bm [1024];
  logic [23:0] col [4];
  bit          prev_vs = 1'b0;
  bit          sh_en = 1'b0;
  int          sh_x = 0;
  int          sh_y = 0;
  int          sh_s = 1;

  function automatic logic [31:0] model_pixel(input int x, input int y, input logic [31:0] rgb);
    int dx;
    int dy;
    logic [1:0] v;
    dx = x - sh_x;
    dy = y - sh_y;
    if (!sh_en || dx < 0 || dy < 0 || dx >= W * sh_s || dy >= H * sh_s) return rgb;
    v = bm[(dy / sh_s) * W + dx / sh_s];
    if (v == 2'd0) return rgb;
    return {8'h00, col[v]};
  endfunction

  // One pixel clock: drive inputs, advance the model, queue the expected output
  task automatic tick(input bit hs_a, input bit vs_a, input bit de_a, input int x, input int y,
                      input logic [31:0] rgb);
    exp_t e;
    in_hsync        = hs_a ^ sync_polarity;
    in_vsync        = vs_a ^ sync_polarity;
    in_active_video = de_a;
    in_rgb          = rgb;
    if (vs_a && !prev_vs) begin
      sh_en = sprite_enable;
      sh_x  = int'(sprite_x);
      sh_y  = int'(sprite_y);
      sh_s  = 1;
`ifdef SPRITE_SCALE2X_EN
      if (sprite_scale) sh_s = 2;
`endif
    end
    prev_vs = vs_a;
    e.hs  = in_hsync;
    e.vs  = in_vsync;
    e.de  = de_a;
    e.rgb = de_a ? model_pixel(x, y, rgb) : rgb;
    e.x   = x;
    e.y   = y;
    if (sprite_wr_en) bm[sprite_wr_addr] = sprite_wr_data;
    if (sprite_col_wr_en && sprite_col_idx != 2'd0) col[sprite_col_idx] = sprite_col_data;
    q.push_back(e);
    @(posedge dvi_clk);
    #1;
    sprite_wr_en     = 1'b0;
    sprite_col_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, $urandom);
  endtask

  task automatic wbm(input int addr, input logic [1:0] data);
    sprite_wr_en   = 1'b1;
    sprite_wr_addr = 10'(addr);
    sprite_wr_data = data;
    tick(1'b0, 1'b0, 1'b0, 0, 0, $urandom);
  endtask

  task automatic wcol(input logic [1:0] idx, input logic [23:0] data);
    sprite_col_wr_en = 1'b1;
    sprite_col_idx   = idx;
    sprite_col_data  = data;
    tick(1'b0, 1'b0, 1'b0, 0, 0, $urandom);
  endtask

  // Frame: 2 vsync lines, 2 back-porch lines, va active lines of ha pixels, 1 front-porch line
  task automatic frame(input int ha, input int va, input bit rnd, input int chg_line,
                       input logic [11:0] chg_x);
    int lt;
    lt = ha + 10;
    got.delete();
    for (int ln = 0; ln < va + 5; ln++) begin
      if (ln == chg_line + 4) sprite_x = chg_x;
      if (rnd && ln == 8) begin
        sprite_enable = 1'($urandom);
        sprite_x      = 12'($urandom_range(ha, 0));
        sprite_y      = 12'($urandom_range(va, 0));
      end
      for (int c = 0; c < lt; c++) begin
        bit   hs_a;
        bit   vs_a;
        bit   de_a;
        int   y;
        logic [31:0] rgb;
        vs_a = (ln < 2);
        hs_a = (c >= ha + 3) && (c < ha + 7);
        de_a = (ln >= 4) && (ln < 4 + va) && (c < ha);
        y    = ln - 4;
        rgb  = rnd ? $urandom : {8'h5A, y[11:0], c[11:0]};
        tick(hs_a, vs_a, de_a, c, y, rgb);
      end
    end
  endtask

  task automatic check_lit(input string name, input int x, input int y, input logic [31:0] exp);
    int k;
    k = y * 4096 + x;
    vectors++;
    if (!got.exists(k)) begin
      miscompares++;
      $display("FAIL %s: pixel (%0d,%0d) not observed, required %h", name, x, y, exp);
    end else if (got[k] !== exp) begin
      miscompares++;
      $display("FAIL %s: pixel (%0d,%0d) got %h required %h", name, x, y, got[k], exp);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the entry queued two clocks earlier
  initial begin
    exp_t e;
    forever begin
      @(negedge dvi_clk);
      if (q.size() >= 3) begin
        e = q.pop_front();
        vectors++;
        if ({out_hsync, out_vsync, out_active_video, out_rgb} !== {e.hs, e.vs, e.de, e.rgb}) begin
          miscompares++;
          $display("FAIL pix (%0d,%0d) de=%0b: got hs%0b vs%0b de%0b %h required hs%0b vs%0b de%0b %h",
                   e.x, e.y, e.de, out_hsync, out_vsync, out_active_video, out_rgb,
                   e.hs, e.vs, e.de, e.rgb);
        end
        if (e.de) got[e.y * 4096 + e.x] = out_rgb;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) col[i] = 24'h0;
    #2 areset = 1'b1;
    // Outputs held at zero under reset whatever the inputs do
    for (int i = 0; i < 6; i++) begin
      in_hsync        = 1'($urandom);
      in_active_video = 1'($urandom);
      in_rgb          = $urandom;
      @(negedge dvi_clk);
      vectors++;
      if ({out_hsync, out_vsync, out_active_video, out_rgb} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset: got %h required 0", {out_hsync, out_vsync, out_active_video, out_rgb});
      end
    end
    @(posedge dvi_clk);
    #1 areset = 1'b0;

    // Sprite disabled: pure 2-cycle passthrough
    idle(4);
    frame(40, 20, 1'b1, -100, 12'd0);
    idle(4);

    // Solid idx-1 sprite at (100,50)
    for (int i = 0; i < 1024; i++) wbm(i, 2'd1);
    wcol(2'd1, 24'h0000FF);
    sprite_enable = 1'b1;
    sprite_x      = 12'd100;
    sprite_y      = 12'd50;
    idle(3);
    frame(140, 90, 1'b0, -100, 12'd0);
    idle(3);
    check_lit("solid_tl", 100, 50, 32'h000000FF);
    check_lit("solid_br", 131, 81, 32'h000000FF);
    check_lit("solid_left", 99, 50, 32'h5A032063);
    check_lit("solid_right", 132, 50, 32'h5A032084);
    check_lit("solid_below", 100, 82, 32'h5A052064);

    // Checkerboard idx 0/2, sprite_x moved to 300 at line 60
    for (int i = 0; i < 1024; i++) wbm(i, (i % 2 == 1) ? 2'd2 : 2'd0);
    wcol(2'd2, 24'h00FF00);
    wcol(2'd0, 24'h123456);
    frame(140, 84, 1'b0, 60, 12'd300);
    idle(3);
    check_lit("chk_even", 100, 50, 32'h5A032064);
    check_lit("chk_odd", 101, 50, 32'h0000FF00);
    check_lit("chk_after_move", 101, 61, 32'h0000FF00);
    check_lit("chk_even_after_move", 100, 61, 32'h5A03D064);
    frame(340, 55, 1'b0, -100, 12'd0);
    idle(3);
    check_lit("moved_odd", 301, 50, 32'h0000FF00);
    check_lit("moved_even", 300, 50, 32'h5A03212C);
    check_lit("moved_old_pos", 101, 50, 32'h5A032065);

    // Clipping at right/bottom of a 48x40 active area
    sprite_x = 12'd30;
    sprite_y = 12'd25;
    frame(48, 40, 1'b0, -100, 12'd0);
    idle(3);
    check_lit("clip_corner", 47, 39, 32'h0000FF00);
    check_lit("clip_even", 46, 39, 32'h5A02702E);
    check_lit("clip_first", 31, 25, 32'h0000FF00);
    check_lit("clip_origin", 0, 0, 32'h5A000000);

`ifdef SPRITE_SCALE2X_EN
    wbm(0, 2'd3);
    wcol(2'd3, 24'hFF0000);
    sprite_x     = 12'd0;
    sprite_y     = 12'd0;
    sprite_scale = 1'b1;
    frame(70, 70, 1'b0, -100, 12'd0);
    idle(3);
    check_lit("x2_00", 0, 0, 32'h00FF0000);
    check_lit("x2_11", 1, 1, 32'h00FF0000);
    check_lit("x2_20", 2, 0, 32'h0000FF00);
    check_lit("x2_end", 63, 63, 32'h0000FF00);
    check_lit("x2_col64", 64, 0, 32'h5A000040);
    check_lit("x2_line64", 0, 64, 32'h5A040000);
`endif

    // Randomized frames with writes coinciding with the vsync edge
    for (int f = 0; f < 5; f++) begin
      int ha;
      int va;
      ha = $urandom_range(64, 40);
      va = $urandom_range(40, 20);
      sync_polarity = 1'($urandom);
      for (int i = 0; i < 48; i++) wbm($urandom_range(1023, 0), 2'($urandom));
      for (int i = 0; i < 3; i++) wcol(2'($urandom), 24'($urandom));
      sprite_enable = ($urandom_range(3, 0) != 0);
      sprite_x      = 12'($urandom_range(ha, 0));
      sprite_y      = 12'($urandom_range(va, 0));
      sprite_scale  = 1'($urandom);
      sprite_wr_en     = 1'b1;
      sprite_wr_addr   = 10'($urandom);
      sprite_wr_data   = 2'($urandom);
      sprite_col_wr_en = 1'b1;
      sprite_col_idx   = 2'($urandom);
      sprite_col_data  = 24'($urandom);
      frame(ha, va, 1'b1, -100, 12'd0);
      idle(3);
    end

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
